trig_capture: RTL and testbench



---
 rtl/trig_capture.sv | 150 +++++++++++++++
 tb/tb_trig_capture.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_capture.sv
// Acquisition/trigger controller: streams ADC samples into a circular sample RAM, keeps a
// pre-trigger window and stops on a full frame. Define TRIG_AUTO_EN for the auto-trigger timeout.
module trig_capture #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned AUTO_TIMEOUT = 65535
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic              arm,
  input  logic              force_trig,
  output logic              wren,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {StIdle, StPre, StWait, StPost, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] wptr_q, pre_cnt_q, post_cnt_q, pretrig_q;
  logic [DATA_W-1:0] level_q, prev_q;
  logic              slope_q, prev_valid_q, force_pend_q;

  logic              write_en, level_hit, auto_hit, trig_fire;
  logic [ADDR_W-1:0] pre_next;

`ifdef TRIG_AUTO_EN
  logic [31:0] auto_cnt_q;
  assign auto_hit = (auto_cnt_q + 32'd1) == 32'(AUTO_TIMEOUT);
`else
  logic unused_auto;
  assign unused_auto = ^AUTO_TIMEOUT;
  assign auto_hit    = 1'b0;
`endif

  assign write_en = sample_en && (state_q inside {StPre, StWait, StPost});
  assign pre_next = pre_cnt_q + 1'b1;

  always_comb begin
    level_hit = 1'b0;
    if (prev_valid_q) begin
      if (!slope_q) level_hit = (prev_q < level_q) && (adc_data >= level_q);
      else          level_hit = (prev_q > level_q) && (adc_data <= level_q);
    end
  end

  assign trig_fire = sample_en && (state_q == StWait) && (level_hit || force_pend_q || auto_hit);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      wptr_q       <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      pretrig_q    <= '0;
      level_q      <= '0;
      prev_q       <= '0;
      slope_q      <= 1'b0;
      prev_valid_q <= 1'b0;
      force_pend_q <= 1'b0;
      wren         <= 1'b0;
      wraddress    <= '0;
      data         <= '0;
      trig_addr    <= '0;
      start_addr   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef TRIG_AUTO_EN
      auto_cnt_q   <= '0;
`endif
    end else begin
      wren <= 1'b0;
      if (write_en) begin
        wren         <= 1'b1;
        wraddress    <= wptr_q;
        data         <= adc_data;
        wptr_q       <= wptr_q + 1'b1;
        prev_q       <= adc_data;
        prev_valid_q <= 1'b1;
      end
      if (force_trig && (state_q inside {StPre, StWait})) force_pend_q <= 1'b1;

      unique case (state_q)
        StIdle, StDone: begin
          // First DONE cycle: the last write is on the bus now, so publish the frame next.
          if (state_q == StDone && !done) begin
            done       <= 1'b1;
            busy       <= 1'b0;
            start_addr <= trig_addr - pretrig_q;
          end else if (arm) begin
            busy         <= 1'b1;
            done         <= 1'b0;
            pre_cnt_q    <= '0;
            prev_valid_q <= 1'b0;
            force_pend_q <= 1'b0;
            level_q      <= trig_level;
            slope_q      <= trig_slope;
            pretrig_q    <= pretrig;
`ifdef TRIG_AUTO_EN
            auto_cnt_q   <= '0;
`endif
            state_q      <= (pretrig == '0) ? StWait : StPre;
          end
        end
        StPre: begin
          if (sample_en) begin
            pre_cnt_q <= pre_next;
            if (pre_next == pretrig_q) begin
              state_q <= StWait;
`ifdef TRIG_AUTO_EN
              auto_cnt_q <= '0;
`endif
            end
          end
        end
        StWait: begin
          if (sample_en) begin
`ifdef TRIG_AUTO_EN
            auto_cnt_q <= auto_cnt_q + 32'd1;
`endif
            if (trig_fire) begin
              trig_addr    <= wptr_q;
              force_pend_q <= 1'b0;
              // Remaining post writes after the trigger sample: DEPTH - pretrig - 1.
              post_cnt_q   <= ~pretrig_q;
              state_q      <= (&pretrig_q) ? StDone : StPost;
            end
          end
        end
        StPost: begin
          if (sample_en) begin
            post_cnt_q <= post_cnt_q - 1'b1;
            if (post_cnt_q == ADDR_W'(1)) state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_capture.sv
// Self-checking bench for trig_capture: randomized sample streams checked against a
// trigger/frame model computed from the sample array.
module tb_trig_capture;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;
  localparam int AUTO   = 20;
  localparam int MAXS   = 4000;

  logic       clock = 1'b0, reset_n = 1'b0, sample_en = 1'b0, trig_slope = 1'b0;
  logic       arm = 1'b0, force_trig = 1'b0;
  logic [7:0] adc_data = '0, trig_level = '0;
  logic [8:0] pretrig = '0;
  logic       wren, busy, done;
  logic [8:0] wraddress, trig_addr, start_addr;
  logic [7:0] data;

  trig_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AUTO_TIMEOUT(AUTO)) dut (
    .clock(clock), .reset_n(reset_n), .sample_en(sample_en), .adc_data(adc_data),
    .trig_level(trig_level), .trig_slope(trig_slope), .pretrig(pretrig), .arm(arm),
    .force_trig(force_trig), .wren(wren), .wraddress(wraddress), .data(data),
    .trig_addr(trig_addr), .start_addr(start_addr), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int         n_cmp = 0, n_err = 0;
  logic [7:0] stim [MAXS];
  logic [7:0] ram_model [DEPTH];
  logic [8:0] wq_addr [$];
  logic [7:0] wq_data [$];
  int         cyc_now = 0, last_wren_cyc = 0, done_rise_cyc = 0;
  logic       done_prev = 1'b0;
  int         wp_model = 0;

  int   e_k, e_writes, e_trig, e_start;
  int   g_writes, g_trig, g_start, g_seq_err, g_frame_err, g_done_lat;
  logic g_done, g_busy;
  logic [1:0] g_arm_state;

  always @(negedge clock) begin
    cyc_now   <= cyc_now + 1;
    done_prev <= done;
    if (wren) begin
      wq_addr.push_back(wraddress);
      wq_data.push_back(data);
      ram_model[wraddress] <= data;
      last_wren_cyc <= cyc_now;
    end
    if (done && !done_prev) done_rise_cyc <= cyc_now;
  end

  // Index of the triggering sample in stim[], or -1 if none within len samples.
  function automatic int model_trig(int p, int level, int slope, int len, int force_at);
    for (int i = p; i < len; i++) begin
      if (i >= 1 && slope == 0 && int'(stim[i-1]) < level && int'(stim[i]) >= level) return i;
      if (i >= 1 && slope == 1 && int'(stim[i-1]) > level && int'(stim[i]) <= level) return i;
      if (force_at >= 0 && i > force_at) return i;
`ifdef TRIG_AUTO_EN
      if (i - p + 1 == AUTO) return i;
`endif
    end
    return -1;
  endfunction

  task automatic acquire(input int p, input int level, input int slope, input int len,
                         input int force_at, input int busy_arm_at, input bit arm_with_sample);
    int idx, wp0;
    wp0      = wp_model;
    e_k      = model_trig(p, level, slope, len, force_at);
    e_writes = (e_k < 0) ? len : e_k + DEPTH - p;
    e_trig   = (wp0 + ((e_k < 0) ? 0 : e_k)) % DEPTH;
    e_start  = (e_trig - p + DEPTH) % DEPTH;
    @(negedge clock);
    wq_addr.delete();
    wq_data.delete();
    trig_level = 8'(level);
    trig_slope = slope[0];
    pretrig    = 9'(p);
    arm        = 1'b1;
    sample_en  = arm_with_sample;
    adc_data   = 8'hEE;
    @(negedge clock);
    arm         = 1'b0;
    sample_en   = 1'b0;
    g_arm_state = {busy, done};
    // Settings must be held from arm, so disturb the live inputs.
    trig_level  = 8'($urandom);
    trig_slope  = 1'($urandom_range(0, 1));
    pretrig     = 9'($urandom);
    idx = 0;
    while (idx < len && !done) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      sample_en = 1'b1;
      adc_data  = stim[idx];
      @(negedge clock);
      sample_en = 1'b0;
      if (idx == force_at) begin
        force_trig = 1'b1;
        @(negedge clock);
        force_trig = 1'b0;
      end
      if (idx == busy_arm_at) begin
        arm = 1'b1;
        @(negedge clock);
        arm = 1'b0;
      end
      idx++;
    end
    repeat (4) @(negedge clock);
    g_done     = done;
    g_busy     = busy;
    g_trig     = int'(trig_addr);
    g_start    = int'(start_addr);
    g_writes   = wq_data.size();
    g_done_lat = done_rise_cyc - last_wren_cyc;
    g_seq_err  = 0;
    for (int i = 0; i < wq_data.size(); i++)
      if (int'(wq_addr[i]) != (wp0 + i) % DEPTH || wq_data[i] !== stim[i]) g_seq_err++;
    g_frame_err = 0;
    if (e_k >= 0)
      for (int j = 0; j < DEPTH; j++)
        if (ram_model[(e_start + j) % DEPTH] !== stim[e_k - p + j]) g_frame_err++;
    wp_model = (wp0 + e_writes) % DEPTH;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_cmp++; if ({wren, busy, done} !== 3'b000) begin n_err++;
      $display("FAIL reset_flags got %b want 000", {wren, busy, done}); end
    n_cmp++; if (wraddress !== 9'd0) begin n_err++;
      $display("FAIL reset_wraddress got %0d want 0", wraddress); end
    n_cmp++; if (data !== 8'd0) begin n_err++; $display("FAIL reset_data got %0d want 0", data); end
    n_cmp++; if (trig_addr !== 9'd0) begin n_err++;
      $display("FAIL reset_trig_addr got %0d want 0", trig_addr); end
    n_cmp++; if (start_addr !== 9'd0) begin n_err++;
      $display("FAIL reset_start_addr got %0d want 0", start_addr); end
    wq_data.delete();
    wq_addr.delete();
    repeat (10) begin
      sample_en = 1'b1; adc_data = 8'($urandom);
      @(negedge clock);
      sample_en = 1'b0;
      @(negedge clock);
    end
    n_cmp++; if (wq_data.size() != 0) begin n_err++;
      $display("FAIL idle_writes got %0d want 0", wq_data.size()); end
    wp_model = 0;
  endtask

  task automatic test_rising();
    for (int i = 0; i < MAXS; i++) stim[i] = 8'(i);
    acquire(100, 8'h80, 0, 1000, -1, -1, 1'b0);
    n_cmp++; if (g_arm_state !== 2'b10) begin n_err++;
      $display("FAIL rise_after_arm busy/done got %b want 10", g_arm_state); end
    n_cmp++; if ({g_done, g_busy} !== 2'b10) begin n_err++;
      $display("FAIL rise_end done/busy got %b want 10", {g_done, g_busy}); end
    n_cmp++; if (g_writes != e_writes) begin n_err++;
      $display("FAIL rise_writes got %0d want %0d", g_writes, e_writes); end
    n_cmp++; if (g_trig != e_trig) begin n_err++;
      $display("FAIL rise_trig_addr got %0d want %0d", g_trig, e_trig); end
    n_cmp++; if (g_start != e_start) begin n_err++;
      $display("FAIL rise_start_addr got %0d want %0d", g_start, e_start); end
    n_cmp++; if (ram_model[e_start] !== 8'h1C) begin n_err++;
      $display("FAIL rise_oldest_sample got %0h want 1c", ram_model[e_start]); end
    n_cmp++; if (g_seq_err != 0 || g_frame_err != 0) begin n_err++;
      $display("FAIL rise_stream bad_writes %0d bad_frame %0d want 0 0", g_seq_err, g_frame_err); end
    n_cmp++; if (g_done_lat != 1) begin n_err++;
      $display("FAIL rise_done_latency got %0d want 1", g_done_lat); end
  endtask

  task automatic test_falling();
    int d;
    // Steer the write pointer close to the top of the buffer first.
    for (int i = 0; i < MAXS; i++) stim[i] = 8'h10;
    d = (505 - wp_model + DEPTH) % DEPTH;
    acquire(0, 8'h80, 1, 1500, (d == 0) ? 511 : d - 1, -1, 1'b0);
    n_cmp++; if (g_writes != e_writes || g_trig != e_trig) begin n_err++;
      $display("FAIL preload writes/trig got %0d/%0d want %0d/%0d", g_writes, g_trig, e_writes, e_trig);
    end
    for (int i = 0; i < MAXS; i++) stim[i] = 8'($urandom);
    acquire($urandom_range(1, 300), $urandom_range(8'h20, 8'hE0), 1, 3000, -1, -1, 1'b0);
    n_cmp++; if (g_done !== (e_k >= 0)) begin n_err++;
      $display("FAIL fall_done got %b want %b", g_done, e_k >= 0); end
    n_cmp++; if (g_writes != e_writes) begin n_err++;
      $display("FAIL fall_writes got %0d want %0d", g_writes, e_writes); end
    n_cmp++; if (g_trig != e_trig || g_start != e_start) begin n_err++;
      $display("FAIL fall_addrs trig/start got %0d/%0d want %0d/%0d", g_trig, g_start, e_trig, e_start);
    end
    n_cmp++; if (g_seq_err != 0 || g_frame_err != 0) begin n_err++;
      $display("FAIL fall_stream bad_writes %0d bad_frame %0d want 0 0", g_seq_err, g_frame_err); end
  endtask

  task automatic test_pretrig_bounds();
    int p;
    for (int c = 0; c < 2; c++) begin
      p = (c == 0) ? 0 : DEPTH - 1;
      for (int i = 0; i < MAXS; i++) stim[i] = 8'($urandom);
      acquire(p, $urandom_range(8'h30, 8'hD0), $urandom_range(0, 1), 3000, -1, -1, 1'b1);
      n_cmp++; if (g_trig != e_trig || g_start != e_start) begin n_err++;
        $display("FAIL bound_p%0d trig/start got %0d/%0d want %0d/%0d", p, g_trig, g_start,
                 e_trig, e_start);
      end
      n_cmp++; if (g_writes - e_k != DEPTH - p) begin n_err++;
        $display("FAIL bound_p%0d post_writes got %0d want %0d", p, g_writes - e_k, DEPTH - p); end
      n_cmp++; if (g_seq_err != 0 || g_frame_err != 0 || g_done !== 1'b1) begin n_err++;
        $display("FAIL bound_p%0d stream bad %0d/%0d done %b want 0/0/1", p, g_seq_err,
                 g_frame_err, g_done);
      end
    end
  endtask

  task automatic test_force();
    for (int i = 0; i < MAXS; i++) stim[i] = 8'h10;
    acquire(50, 8'h80, 0, 1000, 20, 30, 1'b1);
    n_cmp++; if (g_trig != (wp_model - e_writes + 50 + 2 * DEPTH) % DEPTH) begin n_err++;
      $display("FAIL force_trig_addr got %0d want %0d", g_trig,
               (wp_model - e_writes + 50 + 2 * DEPTH) % DEPTH);
    end
    n_cmp++; if (g_writes != e_writes) begin n_err++;
      $display("FAIL force_writes got %0d want %0d", g_writes, e_writes); end
    n_cmp++; if (g_seq_err != 0) begin n_err++;
      $display("FAIL force_stream bad_writes got %0d want 0", g_seq_err); end
  endtask

  task automatic test_auto();
    for (int i = 0; i < MAXS; i++) stim[i] = 8'h10;
`ifdef TRIG_AUTO_EN
    acquire(10, 8'h80, 0, 1000, -1, -1, 1'b0);
    n_cmp++; if (g_trig != e_trig || g_done !== 1'b1) begin n_err++;
      $display("FAIL auto_trig got %0d done %b want %0d done 1", g_trig, g_done, e_trig); end
    n_cmp++; if (g_writes != 29 + DEPTH - 10) begin n_err++;
      $display("FAIL auto_writes got %0d want %0d", g_writes, 29 + DEPTH - 10); end
`else
    acquire(5, 8'h80, 0, 1000, -1, -1, 1'b0);
    n_cmp++; if ({g_busy, g_done} !== 2'b10) begin n_err++;
      $display("FAIL noauto_busy/done got %b want 10", {g_busy, g_done}); end
    n_cmp++; if (g_writes != 1000) begin n_err++;
      $display("FAIL noauto_writes got %0d want 1000", g_writes); end
`endif
  endtask

  task automatic test_reset_mid_post();
    if (!busy) begin
      @(negedge clock);
      pretrig = 9'd5; trig_level = 8'h80; trig_slope = 1'b0; arm = 1'b1;
      @(negedge clock);
      arm = 1'b0;
    end
    adc_data   = 8'h10;
    force_trig = 1'b1;
    @(negedge clock);
    force_trig = 1'b0;
    repeat (12) begin
      sample_en = 1'b1;
      @(negedge clock);
      sample_en = 1'b0;
      @(negedge clock);
    end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midpost_busy got %b want 1", busy); end
    wq_data.delete();
    wq_addr.delete();
    reset_n   = 1'b0;
    sample_en = 1'b1;
    @(negedge clock);
    n_cmp++; if ({busy, done, wren} !== 3'b000 || wraddress !== 9'd0) begin n_err++;
      $display("FAIL midpost_reset busy/done/wren %b wraddress %0d want 000 0",
               {busy, done, wren}, wraddress);
    end
    sample_en = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) begin
      sample_en = 1'b1;
      @(negedge clock);
      sample_en = 1'b0;
      @(negedge clock);
    end
    n_cmp++; if (wq_data.size() != 0 || busy !== 1'b0) begin n_err++;
      $display("FAIL post_reset writes %0d busy %b want 0 0", wq_data.size(), busy); end
    wp_model = 0;
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < MAXS; i++) stim[i] = 8'($urandom);
      acquire($urandom_range(0, DEPTH - 1), $urandom_range(8'h30, 8'hD0), $urandom_range(0, 1),
              3000, -1, -1, 1'b1);
      n_cmp++; if (g_arm_state !== 2'b10) begin n_err++;
        $display("FAIL b2b%0d_rearm busy/done got %b want 10", r, g_arm_state); end
      n_cmp++; if (g_writes != e_writes || g_trig != e_trig || g_start != e_start) begin n_err++;
        $display("FAIL b2b%0d writes/trig/start got %0d/%0d/%0d want %0d/%0d/%0d", r, g_writes,
                 g_trig, g_start, e_writes, e_trig, e_start);
      end
      n_cmp++; if (g_seq_err != 0 || g_frame_err != 0) begin n_err++;
        $display("FAIL b2b%0d_stream bad_writes %0d bad_frame %0d want 0 0", r, g_seq_err,
                 g_frame_err);
      end
      if (e_k >= 0) begin
        n_cmp++; if (g_done_lat != 1 || g_done !== 1'b1) begin n_err++;
          $display("FAIL b2b%0d_done latency %0d done %b want 1 1", r, g_done_lat, g_done); end
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rising();
    test_falling();
    test_pretrig_bounds();
    test_force();
    test_auto();
    test_reset_mid_post();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
